interrupt_sequencer: RTL and testbench

- Consumer side of the CPU status flags: samples I, builds the stacked P byte, and drives the 7-cycle RESET/NMI/IRQ/BRK entry sequence.
- Owns NMI edge detection, IRQ level qualification, priority, NMI hijack, stack push addressing/data and vector fetch addressing.
- Sits between the pin inputs, the instruction decoder and the status register / address bus muxes.

---
 rtl/interrupt_sequencer.sv | 168 ++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: NMI edge/IRQ level qualification, priority, hijack, and the
// seven-cycle RESET/NMI/IRQ/BRK push-and-vector sequence driving the address/data buses.
module interrupt_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] NMI_VEC     = 16'hFFFA,
  parameter logic [15:0] RST_VEC     = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        instr_boundary,
  input  logic        brk_start,
  input  logic [7:0]  p_in,
  input  logic [15:0] pc,
  input  logic [7:0]  sp,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        rw,
  output logic        sp_dec,
  output logic        set_i,
  output logic        load_pcl,
  output logic        load_pch,
  output logic        busy,
  output logic        irq_taken
);

  localparam int unsigned SyncW = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StDummy = 3'd1;
  localparam logic [2:0] StPushH = 3'd2;
  localparam logic [2:0] StPushL = 3'd3;
  localparam logic [2:0] StPushP = 3'd4;
  localparam logic [2:0] StVecL  = 3'd5;
  localparam logic [2:0] StVecH  = 3'd6;

  localparam logic [1:0] KindRst = 2'd0;
  localparam logic [1:0] KindNmi = 2'd1;
  localparam logic [1:0] KindIrq = 2'd2;
  localparam logic [1:0] KindBrk = 2'd3;

  logic [SyncW-1:0] nmi_sync_q, irq_sync_q;
  logic             nmi_sync, irq_sync;
  logic [2:0]       state_q, state_d;
  logic [1:0]       kind_q, kind_d;
  logic [15:0]      vec_sel_q, vec_sel_d;
  logic             nmi_prev_q, nmi_prev_d;
  logic             nmi_pending_q, nmi_pending_d;
  logic             irq_req;
  logic             is_push;
  logic             unused_p;

  assign unused_p = ^p_in[5:4];

  // Synchronizers run on every clk, independent of the cycle enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nmi_sync_q <= '1;
      irq_sync_q <= '1;
    end else begin
      nmi_sync_q[0] <= nmi_n;
      irq_sync_q[0] <= irq_n;
      for (int unsigned i = 1; i < SyncW; i++) begin
        nmi_sync_q[i] <= nmi_sync_q[i-1];
        irq_sync_q[i] <= irq_sync_q[i-1];
      end
    end
  end

  assign nmi_sync = nmi_sync_q[SyncW-1];
  assign irq_sync = irq_sync_q[SyncW-1];
  assign irq_req  = ~irq_sync & ~p_in[2];

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    vec_sel_d     = vec_sel_q;
    nmi_prev_d    = nmi_prev_q;
    nmi_pending_d = nmi_pending_q;
    if (cpu_ce) begin
      nmi_prev_d = nmi_sync;
      case (state_q)
        StIdle: begin
          if (instr_boundary && nmi_pending_q) begin
            state_d = StDummy;
            kind_d  = KindNmi;
          end else if (instr_boundary && irq_req) begin
            state_d = StDummy;
            kind_d  = KindIrq;
          end else if (brk_start) begin
            state_d = StDummy;
            kind_d  = KindBrk;
          end
        end
        StDummy: state_d = StPushH;
        StPushH: state_d = StPushL;
        StPushL: state_d = StPushP;
        StPushP: begin
          state_d = StVecL;
          // A pending NMI hijacks IRQ/BRK entry; reset is never redirected.
          if (kind_q == KindRst)                          vec_sel_d = RST_VEC;
          else if (nmi_pending_q || kind_q == KindNmi)    vec_sel_d = NMI_VEC;
          else                                            vec_sel_d = IRQ_VEC;
        end
        StVecL: begin
          state_d = StVecH;
          if (vec_sel_q == NMI_VEC) nmi_pending_d = 1'b0;
        end
        StVecH:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
      // Placed after the clear so an edge in the same ce stays pending.
      if (nmi_prev_q && !nmi_sync) nmi_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StDummy;
      kind_q        <= KindRst;
      vec_sel_q     <= RST_VEC;
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      vec_sel_q     <= vec_sel_d;
      nmi_prev_q    <= nmi_prev_d;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  assign is_push   = (state_q == StPushH) || (state_q == StPushL) || (state_q == StPushP);
  assign busy      = (state_q != StIdle);
  assign irq_taken = (state_q == StIdle) && instr_boundary && (nmi_pending_q || irq_req);
  assign sp_dec    = is_push;
  assign set_i     = (state_q == StVecL);
  assign load_pcl  = (state_q == StVecL);
  assign load_pch  = (state_q == StVecH);
  // Reset runs the push cycles as reads so nothing is written to the stack.
  assign rw        = is_push ? (kind_q == KindRst) : 1'b1;

  always_comb begin
    addr     = pc;
    data_out = 8'h00;
    case (state_q)
      StPushH: begin
        addr     = {8'h01, sp};
        data_out = pc[15:8];
      end
      StPushL: begin
        addr     = {8'h01, sp};
        data_out = pc[7:0];
      end
      StPushP: begin
        addr     = {8'h01, sp};
        data_out = {p_in[7:6], 1'b1, (kind_q == KindBrk), p_in[3:0]};
      end
      StVecL:  addr = vec_sel_q;
      StVecH:  addr = vec_sel_q + 16'd1;
      default: addr = pc;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer: reset, IRQ, masking, BRK, NMI hijack,
// NMI/IRQ priority, mid-sequence reset abort and cycle-enable freeze.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ce;
  logic        nmi_n;
  logic        irq_n;
  logic        instr_boundary;
  logic        brk_start;
  logic [7:0]  p_in;
  logic [15:0] pc;
  logic [7:0]  sp;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        rw;
  logic        sp_dec;
  logic        set_i;
  logic        load_pcl;
  logic        load_pch;
  logic        busy;
  logic        irq_taken;

  int total  = 0;
  int passed = 0;

  interrupt_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_ce         (cpu_ce),
    .nmi_n          (nmi_n),
    .irq_n          (irq_n),
    .instr_boundary (instr_boundary),
    .brk_start      (brk_start),
    .p_in           (p_in),
    .pc             (pc),
    .sp             (sp),
    .addr           (addr),
    .data_out       (data_out),
    .rw             (rw),
    .sp_dec         (sp_dec),
    .set_i          (set_i),
    .load_pcl       (load_pcl),
    .load_pch       (load_pch),
    .busy           (busy),
    .irq_taken      (irq_taken)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] ea [6];
    ea = '{16'h1234, 16'h01FD, 16'h01FD, 16'h01FD, 16'hFFFC, 16'hFFFD};
    step();
    step();
    total++;
    if (busy !== 1'b1 || rw !== 1'b1 || addr !== 16'h1234 || sp_dec !== 1'b0 || set_i !== 1'b0 ||
        load_pcl !== 1'b0 || load_pch !== 1'b0 || irq_taken !== 1'b0)
      $display("FAIL reset_hold: busy=%b rw=%b addr=%h spd=%b seti=%b pcl=%b pch=%b it=%b want 1 1 1234 0 0 0 0 0",
               busy, rw, addr, sp_dec, set_i, load_pcl, load_pch, irq_taken);
    else passed++;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (addr !== ea[i] || rw !== 1'b1 || busy !== 1'b1 || sp_dec !== (i >= 1 && i <= 3) ||
          set_i !== (i == 4) || load_pcl !== (i == 4) || load_pch !== (i == 5))
        $display("FAIL rst_seq%0d: addr=%h rw=%b spd=%b seti=%b pcl=%b pch=%b want addr=%h rw=1",
                 i, addr, rw, sp_dec, set_i, load_pcl, load_pch, ea[i]);
      else passed++;
      step();
    end
    total++;
    if (busy !== 1'b0) $display("FAIL rst_done_busy: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_irq();
    logic [15:0] ea [6];
    logic [7:0]  ed [6];
    ea = '{16'hC123, 16'h01FF, 16'h01FF, 16'h01FF, 16'hFFFE, 16'hFFFF};
    ed = '{8'h00, 8'hC1, 8'h23, 8'h20, 8'h00, 8'h00};
    pc = 16'hC123; sp = 8'hFF; p_in = 8'h20; irq_n = 1'b0;
    step();
    step();
    instr_boundary = 1'b1;
    #1;
    total++;
    if (irq_taken !== 1'b1) $display("FAIL irq_taken: got %b want 1", irq_taken);
    else passed++;
    step();
    instr_boundary = 1'b0; irq_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (addr !== ea[i] || rw !== !(i >= 1 && i <= 3) || busy !== 1'b1 || irq_taken !== 1'b0 ||
          sp_dec !== (i >= 1 && i <= 3) || set_i !== (i == 4) || load_pcl !== (i == 4) ||
          load_pch !== (i == 5) || ((i >= 1 && i <= 3) && data_out !== ed[i]))
        $display("FAIL irq_seq%0d: addr=%h rw=%b data=%h it=%b want addr=%h data=%h",
                 i, addr, rw, data_out, irq_taken, ea[i], ed[i]);
      else passed++;
      step();
    end
    total++;
    if (busy !== 1'b0) $display("FAIL irq_done_busy: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_masked_irq();
    p_in = 8'h24; irq_n = 1'b0;
    step();
    step();
    instr_boundary = 1'b1;
    #1;
    total++;
    if (irq_taken !== 1'b0) $display("FAIL masked_taken: got %b want 0", irq_taken);
    else passed++;
    step();
    total++;
    if (busy !== 1'b0) $display("FAIL masked_busy: got %b want 0", busy);
    else passed++;
    instr_boundary = 1'b0; irq_n = 1'b1; p_in = 8'h20;
    step();
    step();
  endtask

  task automatic test_brk(input logic hijack);
    logic [15:0] ea [6];
    logic [7:0]  ed [6];
    ea = '{16'h8002, 16'h01FF, 16'h01FF, 16'h01FF, 16'hFFFE, 16'hFFFF};
    ed = '{8'h00, 8'h80, 8'h02, 8'hF3, 8'h00, 8'h00};
    if (hijack) begin
      ea[4] = 16'hFFFA;
      ea[5] = 16'hFFFB;
    end
    pc = 16'h8002; sp = 8'hFF; p_in = 8'hC3; brk_start = 1'b1;
    #1;
    total++;
    if (irq_taken !== 1'b0) $display("FAIL brk_no_taken: got %b want 0", irq_taken);
    else passed++;
    step();
    brk_start = 1'b0;
    // Pin falls in DUMMY; after synchronization the edge is seen on the ce leaving PUSH_L.
    if (hijack) nmi_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (addr !== ea[i] || rw !== !(i >= 1 && i <= 3) || busy !== 1'b1 ||
          sp_dec !== (i >= 1 && i <= 3) || set_i !== (i == 4) || load_pcl !== (i == 4) ||
          load_pch !== (i == 5) || ((i >= 1 && i <= 3) && data_out !== ed[i]))
        $display("FAIL brk%0b_seq%0d: addr=%h rw=%b data=%h want addr=%h data=%h",
                 hijack, i, addr, rw, data_out, ea[i], ed[i]);
      else passed++;
      step();
    end
    total++;
    if (busy !== 1'b0) $display("FAIL brk%0b_done_busy: got %b want 0", hijack, busy);
    else passed++;
    if (hijack) begin
      // Pending NMI must have been consumed: a boundary now takes nothing.
      instr_boundary = 1'b1;
      #1;
      total++;
      if (irq_taken !== 1'b0) $display("FAIL hijack_pending_clr: irq_taken=%b want 0", irq_taken);
      else passed++;
      step();
      total++;
      if (busy !== 1'b0) $display("FAIL hijack_idle: busy=%b want 0", busy);
      else passed++;
      instr_boundary = 1'b0; nmi_n = 1'b1;
      step();
      step();
      step();
    end
    p_in = 8'h20;
  endtask

  task automatic test_nmi_vs_irq();
    logic [15:0] ea [6];
    logic [7:0]  ed [6];
    ea = '{16'h2000, 16'h01FF, 16'h01FF, 16'h01FF, 16'hFFFA, 16'hFFFB};
    ed = '{8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h00};
    pc = 16'h2000; sp = 8'hFF; p_in = 8'h20; nmi_n = 1'b0; irq_n = 1'b0;
    step();
    step();
    step();
    instr_boundary = 1'b1;
    #1;
    total++;
    if (irq_taken !== 1'b1) $display("FAIL nmi_irq_taken: got %b want 1", irq_taken);
    else passed++;
    step();
    instr_boundary = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (addr !== ea[i] || rw !== !(i >= 1 && i <= 3) || busy !== 1'b1 ||
          sp_dec !== (i >= 1 && i <= 3) || set_i !== (i == 4) || load_pcl !== (i == 4) ||
          load_pch !== (i == 5) || ((i >= 1 && i <= 3) && data_out !== ed[i]))
        $display("FAIL nmi_seq%0d: addr=%h rw=%b data=%h want addr=%h data=%h",
                 i, addr, rw, data_out, ea[i], ed[i]);
      else passed++;
      step();
    end
    // The CPU has now set I; the still-low IRQ must be masked.
    p_in = 8'h24;
    instr_boundary = 1'b1;
    #1;
    total++;
    if (irq_taken !== 1'b0) $display("FAIL nmi_then_irq: irq_taken=%b want 0", irq_taken);
    else passed++;
    step();
    total++;
    if (busy !== 1'b0) $display("FAIL nmi_then_idle: busy=%b want 0", busy);
    else passed++;
    instr_boundary = 1'b0; irq_n = 1'b1; nmi_n = 1'b1; p_in = 8'h20;
    step();
    step();
    step();
  endtask

  task automatic test_reset_abort();
    logic [15:0] ea [6];
    ea = '{16'h4000, 16'h01F0, 16'h01F0, 16'h01F0, 16'hFFFC, 16'hFFFD};
    pc = 16'h4000; sp = 8'hF0; brk_start = 1'b1;
    step();
    brk_start = 1'b0;
    step();
    total++;
    if (rw !== 1'b0 || addr !== 16'h01F0) $display("FAIL abort_pre: rw=%b addr=%h want 0 01f0", rw, addr);
    else passed++;
    step();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (busy !== 1'b1 || rw !== 1'b1 || addr !== 16'h4000 || sp_dec !== 1'b0 || set_i !== 1'b0 ||
          load_pcl !== 1'b0 || load_pch !== 1'b0 || irq_taken !== 1'b0)
        $display("FAIL abort_hold%0d: busy=%b rw=%b addr=%h spd=%b want 1 1 4000 0", k, busy, rw, addr, sp_dec);
      else passed++;
      step();
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (addr !== ea[i] || rw !== 1'b1 || busy !== 1'b1 || sp_dec !== (i >= 1 && i <= 3) ||
          set_i !== (i == 4) || load_pcl !== (i == 4) || load_pch !== (i == 5))
        $display("FAIL abort_rst_seq%0d: addr=%h rw=%b want addr=%h rw=1", i, addr, rw, ea[i]);
      else passed++;
      step();
    end
    total++;
    if (busy !== 1'b0) $display("FAIL abort_done_busy: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_ce_freeze();
    pc = 16'h4000; sp = 8'hF0; brk_start = 1'b1;
    step();
    brk_start = 1'b0;
    step();
    cpu_ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (addr !== 16'h01F0 || rw !== 1'b0 || data_out !== 8'h40 || sp_dec !== 1'b1 || busy !== 1'b1)
        $display("FAIL freeze%0d: addr=%h rw=%b data=%h spd=%b want 01f0 0 40 1", k, addr, rw, data_out, sp_dec);
      else passed++;
    end
    cpu_ce = 1'b1;
    step();
    total++;
    if (addr !== 16'h01F0 || rw !== 1'b0 || data_out !== 8'h00)
      $display("FAIL freeze_resume: addr=%h rw=%b data=%h want 01f0 0 00", addr, rw, data_out);
    else passed++;
    step();
    step();
    total++;
    if (addr !== 16'hFFFE || load_pcl !== 1'b1) $display("FAIL freeze_vec: addr=%h pcl=%b want fffe 1", addr, load_pcl);
    else passed++;
    step();
    step();
    total++;
    if (busy !== 1'b0) $display("FAIL freeze_done_busy: got %b want 0", busy);
    else passed++;
  endtask

  initial begin
    reset = 1'b0; cpu_ce = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; instr_boundary = 1'b0;
    brk_start = 1'b0; p_in = 8'h20; pc = 16'h1234; sp = 8'hFD;
    test_reset();
    test_irq();
    test_masked_irq();
    test_brk(1'b0);
    test_brk(1'b1);
    test_nmi_vs_irq();
    test_reset_abort();
    test_ce_freeze();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
